cpu_bus_arbiter: RTL
====================

# cpu_bus_arbiter

Two-port arbiter that shares the single CPU bus master (start/active handshake) between the UART packet decoder (port 0) and a second bus requester (port 1, e.g. a file/DMA engine). Each requester sees a private copy of the CPU master interface. The arbiter serialises transactions, picks winners round-robin, and captures per-port read data. A watchdog aborts transactions that the bus never acknowledges.

## Interface
- dw, 32, data width
- aw, 32, address width
- TIMEOUT, 1024, cycles in REQ without `cpu_active` before abort (≥2)
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- reqN_cpu_start  in  1  request (N = 0,1); level, held until `reqN_cpu_active`
- reqN_cpu_address  in  aw  address, valid while start high
- reqN_cpu_selection  in  4  byte select
- reqN_cpu_write  in  1  1 = write, 0 = read
- reqN_cpu_data_wr  in  dw  write data
- reqN_cpu_active  out  1  per-port active
- reqN_cpu_data_rd  out  dw  last read data of that port's transaction
- cpu_start, cpu_write  out  1  to bus master
- cpu_address  out  aw
- cpu_selection  out  4
- cpu_data_wr  out  dw
- cpu_active  in  1  master busy/acknowledge
- cpu_data_rd  in  dw  master read data, valid when `cpu_active` falls
- bus_grant  out  1  index of the current/last granted port
- bus_timeout  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, REQ, BUSY, HOLD.
- IDLE:
  - If any `reqN_cpu_start` is high, choose the winner. If both are high, the port not granted last wins; after reset, port 0 has priority.
  - Latch the winner's address, selection, write and data_wr into the `cpu_*` outputs. Set `bus_grant`. Set `cpu_start <= 1`. Clear the watchdog. Go to REQ.
- REQ:
  - `cpu_start` stays high and the watchdog increments.
  - If `cpu_active`: `cpu_start <= 0`, go to BUSY.
  - Else, if the watchdog reaches TIMEOUT-1: `cpu_start <= 0`. Pulse `bus_timeout` and `reqN_cpu_active` of the granted port for one cycle. Load that port's `data_rd` with 32'hDEAD_BEEF. Go to HOLD.
- BUSY:
  - When `cpu_active` is low, capture `cpu_data_rd` into the granted port's `data_rd` register (reads only; writes leave it unchanged). Go to HOLD.
- HOLD: one idle cycle, then IDLE. Start inputs are not sampled in HOLD.
- `reqN_cpu_active` (combinational):
  - high = `cpu_active` AND granted port is N AND state ∈ {REQ, BUSY}, OR the registered timeout pulse for N.
  - The non-granted port always sees 0.
- Requester rule: `reqN_cpu_start` must be low by the cycle after `reqN_cpu_active` rises. A start still high in IDLE is treated as a new request.
- The non-granted port's request simply waits; no state is lost.
- `cpu_*` command outputs hold their last values outside REQ. Only `cpu_start` qualifies them.

## Timing
- Reset values:
  - state IDLE, last grant = 1 (so port 0 wins first), watchdog 0.
  - `cpu_start`, `cpu_write`, `cpu_address`, `cpu_selection`, `cpu_data_wr` all 0.
  - `reqN_cpu_data_rd` 0, `bus_grant` 0, `bus_timeout` 0.
- Grant latency: start sampled high in IDLE at edge T → `cpu_start` high after T (1 cycle).
- `reqN_cpu_active` follows `cpu_active` with 0 cycles of latency. `cpu_start` drops at the edge after `cpu_active` is first seen.
- Read data: captured at the edge where BUSY sees `cpu_active` = 0. Valid on `reqN_cpu_data_rd` from the next cycle and held until that port's next read completes.
- Minimum back-to-back spacing: IDLE → REQ → BUSY → HOLD → IDLE, so the next grant is ≥4 cycles after the previous one.
- Reset mid-transaction: everything returns to reset values at the next edge. `cpu_start` drops immediately and read data registers clear.
- Simultaneous requests arriving in HOLD are arbitrated in the following IDLE cycle.

## Test plan
- Single read, port 0: addr 0x0000_1000, sel 0xF. Master acks after 3 cycles and returns 0xCAFE_F00D → `cpu_start` high 1 cycle after request; `req0_cpu_data_rd` = 0xCAFE_F00D; `req1_cpu_active` never high.
- Single write, port 1: addr 0x20, data 0x1234_5678 → `cpu_address` = 0x20, `cpu_write` = 1, `cpu_data_wr` = 0x1234_5678; `bus_grant` = 1; `req1_cpu_data_rd` unchanged.
- Both ports request in the same cycle from reset, then re-request continuously → grants alternate 0,1,0,1. Each transaction completes with its own address and data.
- Port 0 streams 8 reads while port 1 requests once mid-stream → port 1 is granted after port 0's current transaction. No port-0 read data is corrupted.
- Master never asserts active, TIMEOUT=16 → `bus_timeout` pulses 16 cycles after `cpu_start` rises; the granted requester's active pulses once; data_rd = 0xDEAD_BEEF; the arbiter returns to IDLE and serves the next request.
- Assert `rst` while in BUSY → next cycle: all outputs at reset values, state IDLE; a subsequent request is granted to port 0.

Source files
------------

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one CPU bus master between two requesters.
// Round-robin grants, per-port read data, watchdog abort of dead cycles.
module cpu_bus_arbiter #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_cpu_start,
  input  logic [aw-1:0] req0_cpu_address,
  input  logic [3:0]    req0_cpu_selection,
  input  logic          req0_cpu_write,
  input  logic [dw-1:0] req0_cpu_data_wr,
  output logic          req0_cpu_active,
  output logic [dw-1:0] req0_cpu_data_rd,
  input  logic          req1_cpu_start,
  input  logic [aw-1:0] req1_cpu_address,
  input  logic [3:0]    req1_cpu_selection,
  input  logic          req1_cpu_write,
  input  logic [dw-1:0] req1_cpu_data_wr,
  output logic          req1_cpu_active,
  output logic [dw-1:0] req1_cpu_data_rd,
  output logic          cpu_start,
  output logic          cpu_write,
  output logic [aw-1:0] cpu_address,
  output logic [3:0]    cpu_selection,
  output logic [dw-1:0] cpu_data_wr,
  input  logic          cpu_active,
  input  logic [dw-1:0] cpu_data_rd,
  output logic          bus_grant,
  output logic          bus_timeout
);

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  localparam logic [dw-1:0] DEAD = dw'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, HOLD} state_t;

  state_t        state_q;
  logic          last_q;
  logic [WW-1:0] wdog_q;
  logic          start_q;
  logic          write_q;
  logic [aw-1:0] addr_q;
  logic [3:0]    sel_q;
  logic [dw-1:0] wdata_q;
  logic [dw-1:0] rd0_q;
  logic [dw-1:0] rd1_q;
  logic          grant_q;
  logic          to_q;
  logic          win_d;
  logic          busy_w;

  // Port 1 wins when alone, or on a tie if port 0 went last.
  assign win_d = req1_cpu_start &
                 (~req0_cpu_start | ~last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      start_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      grant_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req0_cpu_start | req1_cpu_start) begin
            grant_q <= win_d;
            last_q  <= win_d;
            start_q <= 1'b1;
            wdog_q  <= '0;
            state_q <= REQ;
            if (win_d) begin
              addr_q  <= req1_cpu_address;
              sel_q   <= req1_cpu_selection;
              write_q <= req1_cpu_write;
              wdata_q <= req1_cpu_data_wr;
            end else begin
              addr_q  <= req0_cpu_address;
              sel_q   <= req0_cpu_selection;
              write_q <= req0_cpu_write;
              wdata_q <= req0_cpu_data_wr;
            end
          end
        end
        REQ: begin
          if (cpu_active) begin
            start_q <= 1'b0;
            state_q <= BUSY;
          end else if (wdog_q == WD_MAX) begin
            start_q <= 1'b0;
            to_q    <= 1'b1;
            state_q <= HOLD;
            if (grant_q) rd1_q <= DEAD;
            else         rd0_q <= DEAD;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        BUSY: begin
          if (!cpu_active) begin
            state_q <= HOLD;
            if (!write_q) begin
              if (grant_q) rd1_q <= cpu_data_rd;
              else         rd0_q <= cpu_data_rd;
            end
          end
        end
        HOLD: state_q <= IDLE;
      endcase
    end
  end

  assign busy_w = (state_q == REQ) ||
                  (state_q == BUSY);

  assign req0_cpu_active = ~grant_q &
                           ((cpu_active & busy_w) | to_q);
  assign req1_cpu_active = grant_q &
                           ((cpu_active & busy_w) | to_q);

  assign req0_cpu_data_rd = rd0_q;
  assign req1_cpu_data_rd = rd1_q;
  assign cpu_start     = start_q;
  assign cpu_write     = write_q;
  assign cpu_address   = addr_q;
  assign cpu_selection = sel_q;
  assign cpu_data_wr   = wdata_q;
  assign bus_grant     = grant_q;
  assign bus_timeout   = to_q;

endmodule
